// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - glyph codes, overlay FSM encoding and nibble-to-glyph decode
package seg_pkg;

  // Active-low segment codes, bit order {a,b,c,d,e,f,g,dp}
  localparam logic [7:0] GLY_0     = 8'b00000011;
  localparam logic [7:0] GLY_1     = 8'b10011111;
  localparam logic [7:0] GLY_2     = 8'b00100101;
  localparam logic [7:0] GLY_3     = 8'b00001101;
  localparam logic [7:0] GLY_4     = 8'b10011001;
  localparam logic [7:0] GLY_5     = 8'b01001001;
  localparam logic [7:0] GLY_6     = 8'b01000001;
  localparam logic [7:0] GLY_7     = 8'b00011111;
  localparam logic [7:0] GLY_8     = 8'b00000001;
  localparam logic [7:0] GLY_9     = 8'b00001001;
  localparam logic [7:0] GLY_A     = 8'b00010001;
  localparam logic [7:0] GLY_B     = 8'b11000001;
  localparam logic [7:0] GLY_DASH  = 8'b11111101;
  localparam logic [7:0] GLY_BLANK = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OVL  = 1'b1
  } ovl_state_t;

  // Codes 13..15 decode to an unlit digit; the anode stays enabled
  function automatic logic [7:0] glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'd0:    g = GLY_0;
      4'd1:    g = GLY_1;
      4'd2:    g = GLY_2;
      4'd3:    g = GLY_3;
      4'd4:    g = GLY_4;
      4'd5:    g = GLY_5;
      4'd6:    g = GLY_6;
      4'd7:    g = GLY_7;
      4'd8:    g = GLY_8;
      4'd9:    g = GLY_9;
      4'd10:   g = GLY_A;
      4'd11:   g = GLY_B;
      4'd12:   g = GLY_DASH;
      default: g = GLY_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_scan_sched_if.sv
// rtl/seg_scan_sched_if.sv - display scheduler bus: game source, overlay handshake, an/seg pins
interface seg_scan_sched_if;
  logic [15:0] game_val;
  logic [3:0]  game_blank;
  logic [3:0]  blink_mask;
  logic        ovl_req;
  logic [15:0] ovl_val;
  logic        ovl_busy;
  logic        ovl_done;
  logic [1:0]  digit_sel;
  logic [3:0]  an;
  logic [7:0]  seg;

  modport master (
    output game_val, game_blank, blink_mask, ovl_req, ovl_val,
    input  ovl_busy, ovl_done, digit_sel, an, seg
  );

  modport slave (
    input  game_val, game_blank, blink_mask, ovl_req, ovl_val,
    output ovl_busy, ovl_done, digit_sel, an, seg
  );
endinterface

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running prescaler producing a one-cycle scan tick
module scan_tick_gen #(
  parameter int SCAN_DIV = 17
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [SCAN_DIV-1:0] prescaler;

  // Prescaler wraps naturally; tick is high during the all-ones cycle
  always_ff @(posedge clk) begin
    if (rst) prescaler <= '0;
    else     prescaler <= prescaler + 1'b1;
  end

  assign tick = &prescaler;

endmodule

// File: rtl/seg_scan_sched.sv
// rtl/seg_scan_sched.sv - 4-digit 7-seg scan scheduler with game/overlay arbitration (option: OVL_RETRIGGER_EN)
module seg_scan_sched
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 17,
  parameter int BLINK_DIV = 8,
  parameter int OVL_TICKS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_sched_if.slave    bus
);

  localparam int CW = (OVL_TICKS > 1) ? $clog2(OVL_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(OVL_TICKS - 1);

  logic               tick;
  logic [1:0]         pos;
  logic [BLINK_DIV:0] blink_cnt;
  logic               phase;

  ovl_state_t         state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [15:0]        ovl_lat, ovl_lat_n;
  logic               done_r, done_n;

  logic [15:0]        src;
  logic [3:0]         nib;
  logic               blank_slot;

  logic [3:0]         an_r;
  logic [7:0]         seg_r;
  logic [1:0]         sel_r;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign phase = blink_cnt[BLINK_DIV];

  // Scan position and blink phase both step once per tick
  always_ff @(posedge clk) begin
    if (rst) begin
      pos       <= 2'd0;
      blink_cnt <= '0;
    end else if (tick) begin
      pos       <= pos + 2'd1;
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Pick the owning source and decide whether the current slot is suppressed
  always_comb begin
    src        = (state == ST_OVL) ? ovl_lat : bus.game_val;
    nib        = src[{pos, 2'b00} +: 4];
    blank_slot = (state == ST_IDLE) &&
                 (bus.game_blank[pos] || (bus.blink_mask[pos] && !phase));
  end

  // Pins only change on a tick so a digit slot is never split
  always_ff @(posedge clk) begin
    if (rst) begin
      an_r  <= 4'b1111;
      seg_r <= 8'hFF;
      sel_r <= 2'd0;
    end else if (tick) begin
      sel_r <= pos;
      if (blank_slot) begin
        an_r  <= 4'b1111;
        seg_r <= 8'hFF;
      end else begin
        an_r  <= ~(4'b0001 << pos);
        seg_r <= glyph(nib);
      end
    end
  end

  // Overlay FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ovl_lat <= '0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ovl_lat <= ovl_lat_n;
      done_r  <= done_n;
    end
  end

  // Overlay FSM next state: accept, hold-time countdown, expiry
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ovl_lat_n = ovl_lat;
    done_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.ovl_req) begin
          ovl_lat_n = bus.ovl_val;
          cnt_n     = CNT_LOAD;
          state_n   = ST_OVL;
        end
      end
      ST_OVL: begin
`ifdef OVL_RETRIGGER_EN
        if (bus.ovl_req) begin
          ovl_lat_n = bus.ovl_val;
          cnt_n     = CNT_LOAD;
        end else
`endif
        if (tick) begin
          if (cnt == '0) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.ovl_busy  = (state == ST_OVL);
  assign bus.ovl_done  = done_r;
  assign bus.an        = an_r;
  assign bus.seg       = seg_r;
  assign bus.digit_sel = sel_r;

endmodule
